// File: rtl/cpu_mem_bus_pkg.sv
// Shared CPU bus types: T-phase encoding, HRAM window defaults and the open-bus read value.
package cpu_mem_bus_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } bus_phase_e;

  localparam logic [15:0] HRAM_LO_DEFAULT = 16'hFF80;
  localparam logic [15:0] HRAM_HI_DEFAULT = 16'hFFFE;
  localparam logic [7:0]  BUS_OPEN_VALUE  = 8'hFF;

endpackage

// File: rtl/cpu_mem_bus.sv
// Memory-bus sequencer: 4-phase T-cycle pacing, request latch, external rd/wr strobes, registered read return.
// Latency: request sampled end of T0, strobes T1-T2, read data valid from T3 (one M-cycle = 4 clocks).
// Backpressure: bus_ready low in T2 stalls the phase counter for unblocked accesses; no wait limit.
module cpu_mem_bus
  import cpu_mem_bus_pkg::*;
#(
  parameter logic [15:0] HRAM_LO = HRAM_LO_DEFAULT,
  parameter logic [15:0] HRAM_HI = HRAM_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  t_cycle,
  input  logic        mem_enable,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  mem_data_out,
  output logic [7:0]  mem_data_in,
  input  logic        dma_active,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  bus_data_in,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic        bus_ready
);

  bus_phase_e  phase, phase_nxt;
  logic        req_en, req_wr, req_dma;
  logic [15:0] req_addr;
  logic        req_blocked, req_access;
  logic        in_blocked, in_access;
  logic        rd_nxt, wr_nxt;
  logic [15:0] addr_nxt;
  logic [7:0]  dout_nxt, mdi_nxt;

  assign t_cycle = phase;

  // Only HRAM stays reachable while DMA owns the main bus.
  assign req_blocked = req_dma && ((req_addr < HRAM_LO) || (req_addr > HRAM_HI));
  assign req_access  = req_en && !req_blocked;
  assign in_blocked  = dma_active && ((mem_addr < HRAM_LO) || (mem_addr > HRAM_HI));
  assign in_access   = mem_enable && !in_blocked;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase        <= T0;
      req_en       <= 1'b0;
      req_wr       <= 1'b0;
      req_dma      <= 1'b0;
      req_addr     <= 16'h0000;
      bus_rd       <= 1'b0;
      bus_wr       <= 1'b0;
      bus_addr     <= 16'h0000;
      bus_data_out <= 8'h00;
      mem_data_in  <= 8'h00;
    end else begin
      phase        <= phase_nxt;
      bus_rd       <= rd_nxt;
      bus_wr       <= wr_nxt;
      bus_addr     <= addr_nxt;
      bus_data_out <= dout_nxt;
      mem_data_in  <= mdi_nxt;
      if (phase == T0) begin
        req_en   <= mem_enable;
        req_wr   <= mem_write;
        req_dma  <= dma_active;
        req_addr <= mem_addr;
      end
    end
  end

  always_comb begin
    phase_nxt = phase;
    case (phase)
      T0: phase_nxt = T1;
      T1: phase_nxt = T2;
      T2: phase_nxt = (req_access && !bus_ready) ? T2 : T3;
      T3: phase_nxt = T0;
      default: phase_nxt = T0;
    endcase
  end

  // Next values of the registered outputs; strobes for a new request are
  // decoded from the inputs at T0 so they are already asserted throughout T1.
  always_comb begin
    rd_nxt   = bus_rd;
    wr_nxt   = bus_wr;
    addr_nxt = bus_addr;
    dout_nxt = bus_data_out;
    mdi_nxt  = mem_data_in;
    case (phase)
      T0: begin
        rd_nxt = in_access && !mem_write;
        wr_nxt = in_access && mem_write;
        if (in_access) begin
          addr_nxt = mem_addr;
          if (mem_write) begin
            dout_nxt = mem_data_out;
          end
        end
      end
      T2: begin
        if (phase_nxt == T3) begin
          rd_nxt = 1'b0;
          wr_nxt = 1'b0;
          if (req_en && !req_wr) begin
            mdi_nxt = req_blocked ? BUS_OPEN_VALUE : bus_data_in;
          end
        end
      end
      T3: begin
        rd_nxt = 1'b0;
        wr_nxt = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_mem_bus.sv
// Directed bench for cpu_mem_bus with a queue scoreboard of expected read-return values.
// Latency: checks each T-phase per M-cycle. Backpressure: exercises bus_ready wait states.
module tb_cpu_mem_bus;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  t_cycle;
  logic        mem_enable = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_addr = 16'h0000;
  logic [7:0]  mem_data_out = 8'h00;
  logic [7:0]  mem_data_in;
  logic        dma_active = 1'b0;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_in = 8'h00;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  exp_mdi = 8'h00;
  logic [15:0] exp_baddr = 16'h0000;
  logic [7:0]  exp_bdout = 8'h00;

  cpu_mem_bus dut (
    .clk          (clk),
    .reset        (reset),
    .t_cycle      (t_cycle),
    .mem_enable   (mem_enable),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .dma_active   (dma_active),
    .bus_addr     (bus_addr),
    .bus_data_out (bus_data_out),
    .bus_data_in  (bus_data_in),
    .bus_rd       (bus_rd),
    .bus_wr       (bus_wr),
    .bus_ready    (bus_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [1:0] ph, input logic rd, input logic wr);
    chk({tag, ".t_cycle"}, 16'(t_cycle), 16'(ph));
    chk({tag, ".bus_rd"}, 16'(bus_rd), 16'(rd));
    chk({tag, ".bus_wr"}, 16'(bus_wr), 16'(wr));
    chk({tag, ".bus_addr"}, bus_addr, exp_baddr);
    chk({tag, ".bus_data_out"}, 16'(bus_data_out), 16'(exp_bdout));
  endtask

  // One full M-cycle, entered and left at a negedge in T0.
  task automatic m_cycle(input string tag, input logic en, input logic wr, input logic [15:0] addr,
                         input logic [7:0] dout, input logic dma, input logic [7:0] bdin, input int waits);
    logic blk, acc, exp_rd, exp_wr;
    blk    = dma && ((addr < 16'hFF80) || (addr > 16'hFFFE));
    acc    = en && !blk;
    exp_rd = acc && !wr;
    exp_wr = acc && wr;
    chk({tag, ".t0"}, 16'(t_cycle), 16'd0);
    mem_enable = en; mem_write = wr; mem_addr = addr; mem_data_out = dout; dma_active = dma;
    if (en && !wr) exp_q.push_back(blk ? 8'hFF : bdin);
    else exp_q.push_back(exp_mdi);
    @(negedge clk);
    if (acc) begin
      exp_baddr = addr;
      if (wr) exp_bdout = dout;
    end
    chk_outputs({tag, ".T1"}, 2'd1, exp_rd, exp_wr);
    chk({tag, ".T1.mem_data_in"}, 16'(mem_data_in), 16'(exp_mdi));
    // Inputs after T0 must be ignored, including a DMA change.
    mem_enable = ~en; mem_write = ~wr; mem_addr = ~addr; mem_data_out = ~dout; dma_active = ~dma;
    bus_data_in = 8'($urandom);
    bus_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k <= (acc ? waits : 0); k++) begin
      chk_outputs($sformatf("%s.T2w%0d", tag, k), 2'd2, exp_rd, exp_wr);
      if (acc) begin
        bus_ready   = (k == waits);
        bus_data_in = (k == waits) ? bdin : 8'($urandom);
      end else begin
        bus_ready   = 1'b0;
        bus_data_in = bdin;
      end
      @(negedge clk);
    end
    chk_outputs({tag, ".T3"}, 2'd3, 1'b0, 1'b0);
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $error("FAIL %s.scoreboard: observed empty queue expected entry", tag);
    end else begin
      exp_mdi = exp_q.pop_front();
      chk({tag, ".T3.mem_data_in"}, 16'(mem_data_in), 16'(exp_mdi));
    end
    bus_ready = 1'b1;
    mem_enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    chk_outputs("reset", 2'd0, 1'b0, 1'b0);
    chk("reset.mem_data_in", 16'(mem_data_in), 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    m_cycle("rd_c000", 1'b1, 1'b0, 16'hC000, 8'h00, 1'b0, 8'h3E, 0);
    m_cycle("wr_8000", 1'b1, 1'b1, 16'h8000, 8'hA5, 1'b0, 8'h11, 0);
    m_cycle("rd_wait3", 1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 8'h77, 3);
    m_cycle("idle", 1'b0, 1'b0, 16'h2222, 8'h99, 1'b0, 8'h44, 0);
    m_cycle("dma_rd_0100", 1'b1, 1'b0, 16'h0100, 8'h00, 1'b1, 8'h12, 2);
    m_cycle("dma_rd_ff90", 1'b1, 1'b0, 16'hFF90, 8'h00, 1'b1, 8'h5A, 1);
    m_cycle("dma_wr_c000", 1'b1, 1'b1, 16'hC000, 8'hC3, 1'b1, 8'h00, 0);
    m_cycle("dma_rd_ff80", 1'b1, 1'b0, 16'hFF80, 8'h00, 1'b1, 8'h81, 0);
    m_cycle("dma_rd_fffe", 1'b1, 1'b0, 16'hFFFE, 8'h00, 1'b1, 8'hE7, 0);
    m_cycle("dma_rd_ff7f", 1'b1, 1'b0, 16'hFF7F, 8'h00, 1'b1, 8'h22, 0);
    m_cycle("dma_rd_ffff", 1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b1, 8'h33, 0);
    m_cycle("dma_wr_ff85", 1'b1, 1'b1, 16'hFF85, 8'h6D, 1'b1, 8'h00, 0);
    m_cycle("rd_wait0b", 1'b1, 1'b0, 16'h4000, 8'h00, 1'b0, 8'h00, 0);

    // Reset in T2 of a stalled write.
    mem_enable = 1'b1; mem_write = 1'b1; mem_addr = 16'h4000; mem_data_out = 8'h3C; dma_active = 1'b0;
    @(negedge clk);
    mem_enable = 1'b0;
    bus_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid.pre.bus_wr", 16'(bus_wr), 16'h0001);
    chk("rst_mid.pre.t_cycle", 16'(t_cycle), 16'h0002);
    #2 reset = 1'b1;
    #1;
    exp_mdi = 8'h00; exp_baddr = 16'h0000; exp_bdout = 8'h00;
    chk_outputs("rst_mid", 2'd0, 1'b0, 1'b0);
    chk("rst_mid.mem_data_in", 16'(mem_data_in), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    bus_ready = 1'b1;

    m_cycle("post_rst_rd", 1'b1, 1'b0, 16'hC001, 8'h00, 1'b0, 8'h9B, 1);
    m_cycle("post_rst_wr", 1'b1, 1'b1, 16'hD000, 8'h5E, 1'b0, 8'h00, 2);

    chk("scoreboard.empty", 16'(exp_q.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_mem_bus.md
# cpu_mem_bus

Memory-bus sequencer directly downstream of the CPU control/datapath. It generates the free-running 4-phase `t_cycle` count that paces the microcode. It latches the CPU's per-M-cycle memory request and drives the external system bus with read/write strobes. It returns registered read data as `mem_data_in` for instruction load and microcode dispatch. It also applies OAM-DMA bus blocking and external wait-state stalls.

## Interface
- `HRAM_LO`, default 16'hFF80, lowest address still CPU-accessible during DMA
- `HRAM_HI`, default 16'hFFFE, highest address still CPU-accessible during DMA
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `t_cycle`  out  2  current T-phase 0..3; the CPU advances microstate when it is 3
- `mem_enable`  in  1  CPU requests a memory access this M-cycle
- `mem_write`  in  1  access is a write (valid only with `mem_enable`)
- `mem_addr`  in  16  access address from the datapath
- `mem_data_out`  in  8  CPU write data
- `mem_data_in`  out  8  registered read data to the CPU
- `dma_active`  in  1  OAM DMA owns the main bus
- `bus_addr`  out  16  external address
- `bus_data_out`  out  8  external write data
- `bus_data_in`  in  8  external read data
- `bus_rd`  out  1  read strobe
- `bus_wr`  out  1  write strobe
- `bus_ready`  in  1  target ready; low inserts wait states

## Operation
- Phase counter: T0→T1→T2→T3→T0. It holds at T2 while a bus access is active and `bus_ready`=0.
- On the edge ending T0, the block latches `mem_enable`, `mem_write`, `mem_addr`, `mem_data_out` and `dma_active` into an internal request. CPU inputs are ignored at all other phases.
- A request is blocked when the latched `dma_active`=1 and the address is outside [`HRAM_LO`,`HRAM_HI`].
- Unblocked read:
  - `bus_addr` = latched address from T1.
  - `bus_rd`=1 during T1 and T2.
  - `bus_data_in` is captured into `mem_data_in` on the edge leaving T2.
- Unblocked write:
  - `bus_addr`/`bus_data_out` are driven from T1.
  - `bus_wr`=1 during T1 and T2.
  - `mem_data_in` is unchanged.
- Blocked read: no strobes; `mem_data_in` ← 8'hFF on the edge leaving T2.
- Blocked write: no strobes; the write is dropped silently.
- No request (`mem_enable`=0): no strobes; `mem_data_in` holds its value.
- `bus_addr`/`bus_data_out` hold their last driven values between accesses.
- `bus_rd` and `bus_wr` are never both 1.

## Timing
- Reset values: `t_cycle`=0, `bus_rd`=0, `bus_wr`=0, `bus_addr`=16'h0000, `bus_data_out`=8'h00, `mem_data_in`=8'h00 (decodes as NOP at dispatch). Latched request cleared.
- Reset mid-access deasserts strobes immediately (asynchronous), with no partial write completion. The first post-reset edge moves T0→T1.
- All outputs are registered; there is no combinational path from CPU inputs to bus outputs.
- Access latency with zero waits: request sampled end of T0; data valid in `mem_data_in` throughout T3 and until the next capture. One M-cycle = 4 clocks.
- Wait states:
  - While in T2 with an active unblocked access and `bus_ready`=0, `t_cycle` stays 2 and strobes stay asserted.
  - The edge on which `bus_ready`=1 completes the access and enters T3.
  - There is no wait limit.
- `bus_ready` is ignored for blocked or absent requests; T2→T3 is unconditional.
- `dma_active` changing after T0 does not affect the in-flight access.

## Structure
- Shared CPU package: `bus_phase_e` {T0,T1,T2,T3} (2-bit), constants `HRAM_LO_DEFAULT`/`HRAM_HI_DEFAULT`, and `BUS_OPEN_VALUE`=8'hFF.
- Single module. The phase counter and request latch are small enough that no sub-module is warranted.
- The HRAM window check is an inline comparison on the latched address.

## Test plan
- Read at 16'hC000, `bus_data_in`=8'h3E, ready high → `bus_rd` high T1–T2, `mem_data_in`=8'h3E at T3, `t_cycle` sequence 0,1,2,3.
- Write 8'hA5 to 16'h8000 → `bus_wr` high T1–T2, `bus_data_out`=8'hA5, `mem_data_in` unchanged.
- Read with `bus_ready` low for 3 clocks → `t_cycle` holds 2 for 4 clocks total, strobes held, data captured on ready edge.
- `dma_active`=1:
  - Read 16'h0100 → no `bus_rd`, `mem_data_in`=8'hFF.
  - Read 16'hFF90 → normal bus read.
  - Write 16'hC000 → no `bus_wr`.
- Assert `reset` during T2 of a write → `bus_wr` drops at once, all outputs reach reset values, and the counter resumes from T0.
